fetch_queue: RTL

Parametrised instruction-fetch front end for the pipelined RV core. Replaces the bare IF PC register and stall-muxed IMEM address with a prefetch queue.
- Drives the synchronous IMEM port (1-cycle read latency).
- Buffers up to DEPTH {pc, instruction} pairs.
- Presents them to decode through a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the queue and killing the in-flight fetch.

---
 rtl/fetch_queue.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end for the pipelined RV core. It issues sequential
// reads to a synchronous IMEM (1-cycle read latency) and keeps up to DEPTH
// {pc, instruction} pairs in a circular buffer. The head of that buffer is
// presented to decode. A redirect from EX flushes the buffer, discards the
// response arriving in the redirect cycle and restarts fetch at the target.
//
// Optional build macro: FETCH_BYPASS_EN
//   When defined, a response that arrives while the buffer is empty is shown
//   to decode in the same cycle. If decode accepts it, the entry is not
//   written into the buffer. When undefined, every response passes through
//   the buffer.
//
// Parameters
//   XLEN      PC / address width
//   DEPTH     buffer entries (power of 2, >= 2)
//   RESET_PC  first fetch address after reset (4-byte aligned)
//
// Ports
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   imem_en         out  IMEM read request this cycle
//   imem_addr       out  IMEM byte address, bits [1:0] always 0
//   imem_rdata      in   IMEM data, valid the cycle after imem_en
//   redirect_valid  in   branch taken / jump from EX
//   redirect_pc     in   redirect target, bits [1:0] ignored
//   id_ready        in   decode accepts the head entry
//   id_valid        out  head entry valid
//   id_pc           out  PC of head entry (0 while empty)
//   id_instr        out  instruction of head entry (0 while empty)
//   count           out  entries currently held in the buffer
//
// Handshake: an entry moves to decode on every clk edge where id_valid and
// id_ready are both high. id_valid does not depend on id_ready, and while
// id_valid is high and id_ready is low the head (id_pc/id_instr) is held.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       imem_en,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [31:0]                imem_rdata,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   input  logic                       id_ready,
   output logic                       id_valid,
   output logic [XLEN-1:0]            id_pc,
   output logic [31:0]                id_instr,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // State
   logic [XLEN-1:0] r_fetch_pc;
   logic            r_inflight;
   logic [XLEN-1:0] r_inflight_pc;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_q_pc    [DEPTH];
   logic [31:0]     r_q_instr [DEPTH];

   // Combinational
   logic            w_redir;
   logic            w_kill;
   logic            w_rsp;
   logic            w_head_valid;
   logic [XLEN-1:0] w_head_pc;
   logic [31:0]     w_head_instr;
   logic            w_bypass;
   logic            w_pop;
   logic            w_pop_q;
   logic            w_push;
   logic [CW:0]     w_occ;
   logic            w_issue_ok;
   logic [XLEN-1:0] w_redirect_addr;

   // Redirect is ignored while reset is held so the outputs keep reset values.
   assign w_redir         = rst_n && redirect_valid;
   assign w_redirect_addr = {redirect_pc[XLEN-1:2], 2'b00};

   // The response landing in the redirect cycle belongs to the old path.
   // The request issued in the redirect cycle itself is never killed.
   assign w_kill = w_redir;
   assign w_rsp  = r_inflight && !w_kill;

   always_comb begin
      w_head_valid = (r_count != '0);
      w_head_pc    = w_head_valid ? r_q_pc[r_rd_ptr]    : '0;
      w_head_instr = w_head_valid ? r_q_instr[r_rd_ptr] : '0;
      w_bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
      if (!w_head_valid && w_rsp) begin
         w_bypass     = 1'b1;
         w_head_valid = 1'b1;
         w_head_pc    = r_inflight_pc;
         w_head_instr = imem_rdata;
      end
`else
`endif
   end

   assign id_valid = w_head_valid && !w_redir;
   assign id_pc    = w_head_pc;
   assign id_instr = w_head_instr;
   assign count    = r_count;

   assign w_pop   = id_valid && id_ready;
   // A bypassed entry that decode takes never occupies a buffer slot.
   assign w_pop_q = w_pop && !w_bypass;
   assign w_push  = w_rsp && !(w_bypass && id_ready);

   // Occupancy the buffer would reach if every outstanding response lands.
   // pop never exceeds count + inflight, so this cannot underflow.
   assign w_occ      = (CW+1)'(r_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
   assign w_issue_ok = w_occ < (CW+1)'(DEPTH);

   assign imem_en   = rst_n && (w_redir || w_issue_ok);
   assign imem_addr = w_redir ? w_redirect_addr : r_fetch_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= RESET_PC;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
      end else if (w_redir) begin
         // Flush: drop everything buffered and restart at the target.
         r_count       <= '0;
         r_rd_ptr      <= r_wr_ptr;
         r_inflight    <= 1'b1;
         r_inflight_pc <= w_redirect_addr;
         r_fetch_pc    <= w_redirect_addr + XLEN'(4);
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop_q) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count    <= r_count + CW'(w_push) - CW'(w_pop_q);
         r_inflight <= w_issue_ok;
         if (w_issue_ok) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + XLEN'(4);
         end
      end
   end

   // Entry storage needs no reset; r_count says which slots are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr]    <= r_inflight_pc;
         r_q_instr[r_wr_ptr] <= imem_rdata;
      end
   end

   // The issue throttle must make a push into a full buffer impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && (r_count == CW'(DEPTH))));

endmodule
